// File: rtl/block_quantizer_if.sv
// block_quantizer_if: bundles the input stream, the output stream and the
// per-block scale side-band of the block quantizer.
//
// Handshake rule (both streams): a beat transfers on a rising clock edge where
// valid && ready are both high. Once valid is raised it stays high, and the
// beat and its side-band stay constant, until that transfer happens.
//
// Signals:
//   data_in        ELEMS x IN_WIDTH   input beat (signed elements)
//   data_in_valid  producer has a beat
//   data_in_ready  quantizer accepts a beat (FILL phase only)
//   data_out       ELEMS x OUT_WIDTH  quantized beat (signed elements)
//   data_out_valid quantizer presents a beat (DRAIN phase only)
//   data_out_ready consumer accepts the beat
//   data_out_last  beat is the final one of the block
//   scale_shift    power-of-two shift s of the block being drained
//   max_num        unsigned |x| maximum of the block being drained
//   fsm_state      quantizer phase, for debug/observation
// Modports: slave = quantizer side, master = producer/consumer side.
interface block_quantizer_if #(
  parameter int IN_WIDTH    = 16,
  parameter int ELEMS       = 4,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = $clog2(IN_WIDTH + 1)
);
  logic [ELEMS-1:0][IN_WIDTH-1:0]  data_in;
  logic                            data_in_valid;
  logic                            data_in_ready;
  logic [ELEMS-1:0][OUT_WIDTH-1:0] data_out;
  logic                            data_out_valid;
  logic                            data_out_ready;
  logic                            data_out_last;
  logic [SHIFT_WIDTH-1:0]          scale_shift;
  logic [IN_WIDTH-1:0]             max_num;
  logic [1:0]                      fsm_state;

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last,
           scale_shift, max_num, fsm_state
  );

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last,
           scale_shift, max_num, fsm_state
  );
endinterface

// File: rtl/block_quantizer.sv
// block_quantizer: buffers a block of IN_DEPTH beats of signed fixed-point
// data while tracking the block's absolute maximum, derives a power-of-two
// scale shift from that maximum, then replays the block as saturated,
// (optionally) rounded signed OUT_WIDTH integers.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (discards any partial block)
//   bus  block_quantizer_if.slave: input stream, output stream, scale
//        side-band (scale_shift, max_num) and fsm_state debug view.
//
// Phases: FILL (accept IN_DEPTH beats) -> CALC (one cycle, register shift and
// max) -> DRAIN (emit IN_DEPTH quantized beats) -> FILL. Phases never overlap.
module block_quantizer #(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int IN_DEPTH       = 4,
  parameter int OUT_WIDTH      = 8,
  parameter int ROUNDING       = 1,
  parameter int SHIFT_WIDTH    = $clog2(IN_WIDTH + 1)
) (
  input logic           clk,
  input logic           rst,
  block_quantizer_if.slave bus
);
  localparam int N     = IN_PARALLELISM * IN_SIZE;
  localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IN_DEPTH - 1);
  // Symmetric saturation bounds; the most-negative OUT_WIDTH code is never produced.
  localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH + 1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [IN_WIDTH:0] EXT_ONE = (IN_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;
  logic [IN_WIDTH-1:0]            max_q, max_num_q, beat_max;
  logic [SHIFT_WIDTH-1:0]         shift_q, shift_calc, bit_len;
  logic [N-1:0][IN_WIDTH-1:0]     buffer [IN_DEPTH];
  logic [N-1:0][OUT_WIDTH-1:0]    q_beat;
  logic                           in_ready, out_valid, in_fire, out_fire;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign in_fire   = in_ready && bus.data_in_valid;
  assign out_fire  = out_valid && bus.data_out_ready;

  assign bus.data_in_ready  = in_ready;
  assign bus.data_out_valid = out_valid;
  assign bus.data_out_last  = out_valid && (rd_ptr == LAST_PTR);
  assign bus.data_out       = q_beat;
  assign bus.scale_shift    = shift_q;
  assign bus.max_num        = max_num_q;
  assign bus.fsm_state      = state_q;

  // Largest |x| in the incoming beat. Magnitude is unsigned IN_WIDTH, so the
  // most-negative input maps to 2^(IN_WIDTH-1) without overflow.
  always_comb begin : beat_abs_max
    logic [IN_WIDTH-1:0] elem;
    logic [IN_WIDTH-1:0] mag;
    beat_max = '0;
    for (int i = 0; i < N; i++) begin
      elem = bus.data_in[i];
      mag  = elem[IN_WIDTH-1] ? (~elem + IN_WIDTH'(1)) : elem;
      if (mag > beat_max) beat_max = mag;
    end
  end

  // Shift so the block maximum fits in OUT_WIDTH-1 magnitude bits.
  always_comb begin
    bit_len = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (max_q[i]) bit_len = SHIFT_WIDTH'(i + 1);
    end
    shift_calc = (bit_len > SHIFT_WIDTH'(OUT_WIDTH - 1))
               ? bit_len - SHIFT_WIDTH'(OUT_WIDTH - 1) : '0;
  end

  // Quantize the beat at rd_ptr. One extra bit of headroom keeps x + 2^(s-1)
  // from wrapping before the arithmetic shift.
  always_comb begin : quantize
    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] xe;
    logic signed [IN_WIDTH:0] y;
    q_beat = '0;
    rnd    = '0;
    if (ROUNDING != 0 && shift_q != '0) rnd = EXT_ONE <<< (shift_q - SHIFT_WIDTH'(1));
    for (int i = 0; i < N; i++) begin
      xe = signed'({buffer[rd_ptr][i][IN_WIDTH-1], buffer[rd_ptr][i]});
      y  = (xe + rnd) >>> shift_q;
      if (y > SAT_MAX) y = SAT_MAX;
      else if (y < SAT_MIN) y = SAT_MIN;
      q_beat[i] = y[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (in_fire && wr_ptr == LAST_PTR) state_d = CALC;
      CALC:    state_d = DRAIN;
      DRAIN:   if (out_fire && rd_ptr == LAST_PTR) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      max_q     <= '0;
      shift_q   <= '0;
      max_num_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        if (beat_max > max_q) max_q <= beat_max;
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (state_q == CALC) begin
        shift_q   <= shift_calc;
        max_num_q <= max_q;
      end
      if (out_fire) begin
        if (rd_ptr == LAST_PTR) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          max_q  <= '0;
        end else begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Block storage needs no reset: it is always fully written before DRAIN.
  always_ff @(posedge clk) begin
    if (in_fire) buffer[wr_ptr] <= bus.data_in;
  end
endmodule
